timer_arbiter: RTL
==================

# timer_arbiter

Shares one prescaled countdown timer among NREQ requesters (game logic, display sequencer, sound engine) using round-robin arbitration. A requester raises `req` with a delay in ticks. The block grants the timer, counts the delay on the shared prescaled time base, and pulses `done` to that requester. It sits beside the clock divider on the 100 MHz system clock and replaces per-requester divide counters with one counter pair.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `DW`, default 16: delay and remaining-count width in ticks.
- `PRESCALE`, default 1000000: system cycles per tick (100 Hz at 100 MHz); must be ≥ 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  NREQ  per-requester request level.
- `dly`  in  NREQ*DW  per-requester delay in ticks; slice i is `dly[i*DW +: DW]`.
- `grant`  out  NREQ  one-hot; high while that requester owns the timer.
- `done`  out  NREQ  one-cycle pulse to the owner on expiry.
- `busy`  out  1  high in RUN or DONE.
- `remaining`  out  DW  ticks left for the current owner; 0 when idle.
- `owner`  out  $clog2(NREQ)  index of the current or most recent winner.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** if any `req` bit is high, select the winner by round-robin. The search starts at `last+1` mod NREQ.
  - Load `remaining` with that requester's `dly` slice and clear the prescaler.
  - Set `grant[w]`, `owner`=w, `last`=w, and go to RUN.
  - `dly` is sampled only in this cycle; later changes are ignored.
- **RUN:** the prescaler counts 0..PRESCALE-1 and wraps.
  - On a wrap with `remaining`>1: decrement `remaining`.
  - On a wrap with `remaining`==1: set `remaining` to 0 and go to DONE.
  - If `remaining`==0 on entry (dly=0): go to DONE on the first RUN cycle.
- **Abort:** if `req[owner]` is low in any RUN cycle, return to IDLE. Clear `grant`, `remaining` and the prescaler. No `done` pulse is issued. `last` keeps the aborted owner.
- **DONE:** `done[owner]`=1 and `grant`=0 for exactly one cycle, then go to IDLE.
  - The requester must drop `req` by the cycle after `done`.
  - A request still high in IDLE is treated as a new request and arbitrated normally. Round-robin places it behind the other pending requesters.
- Requests arriving while `busy` wait; no queueing beyond the `req` level is needed.
- **Reset:** state IDLE; `grant`, `done`, `busy`, `remaining`, `owner` and the prescaler all 0; `last`=NREQ-1, so requester 0 wins first. Reset mid-RUN drops `grant` immediately (asynchronous) and no `done` is issued.
- **Arithmetic:** the prescaler is $clog2(PRESCALE) bits wide, minimum 1. `remaining` never underflows. An all-ones delay counts the full 2^DW-1 ticks.

## Timing
- `req` is sampled high in IDLE at cycle T. `grant` and `busy` rise at T+1.
- For dly=D≥1: `grant` stays high for cycles T+1 .. T+D·PRESCALE. `done` pulses at T+D·PRESCALE+1, with `grant` low in that cycle.
- For dly=0: `grant` is high at T+1 only and `done` pulses at T+2.
- `remaining` decrements on the cycle after each prescaler wrap.
- Back-to-back: the next winner's `grant` rises at the cycle after DONE+1. The minimum gap between grants is 2 cycles: DONE, then IDLE.
- Abort: `req[owner]` is low at cycle A in RUN. `grant` and `busy` are low at A+1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `timer_arb_pkg`: state encoding constants (IDLE/RUN/DONE) and the default PRESCALE and DW.
- Sub-module `rr_arbiter` (NREQ): inputs are `req` and `last`; outputs are one-hot `gnt`, `idx` and `any`. It is purely combinational. The FSM registers its result.
- The top level holds the FSM, the prescaler, the `remaining` counter and the output registers.

## Test plan
All scenarios use PRESCALE=4, NREQ=4, DW=8.
1. Reset, then assert req0 with dly=3 at T → `grant`=0001 at T+1 through T+12; `remaining` steps 3→2→1→0; `done`=0001 at T+13; `busy` low at T+14.
2. Assert req0..req3 together, all with dly=1 → grants in order 0, 1, 2, 3. Each `done` is 4 cycles after its grant rises, and each new grant rises 2 cycles after the previous `done`.
3. req2 is held high continuously with dly=1 while req1 pulses once → the order is 2, 1, 2. req2 is not granted twice in a row while req1 is pending.
4. req1 with dly=0 → `grant` is high for 1 cycle, then `done`=0010 the next cycle; `remaining` stays 0.
5. req0 with dly=5; drop req0 after 7 RUN cycles → `grant` is 0 the next cycle, there is no `done` pulse, and a pending req1 is granted 1 cycle later.
6. Assert `rst_n`=0 asynchronously mid-RUN with dly=9 → `grant`, `busy` and `remaining` go to 0 without waiting for a clock edge. After release, req0 wins first.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg
// Shared definitions for the round-robin timer arbiter: FSM state encoding
// and default parameter values for a 100 MHz system clock.
package timer_arb_pkg;

    // Default time base: 1,000,000 system cycles per tick (100 Hz at 100 MHz)
    localparam int DEF_PRESCALE = 1000000;
    localparam int DEF_DW       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin selector. The search starts one past the
// most recent winner and wraps, so every pending requester is served in turn.
// The caller registers the result.
//
// Ports:
//   req   in  NREQ          request levels
//   last  in  $clog2(NREQ)  index of the most recent winner
//   gnt   out NREQ          one-hot selected requester (0 if none)
//   idx   out $clog2(NREQ)  index of the selected requester
//   any   out 1             at least one request is pending
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // k = 1..NREQ visits last+1 first and last itself at the very end
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(last) + k) % NREQ]) begin
                any = 1'b1;
                gnt[(int'(last) + k) % NREQ] = 1'b1;
                idx = IW'((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter
// Shares one prescaled countdown timer among NREQ requesters. A winner is
// picked round-robin, its delay (in ticks) is counted on a shared prescaler,
// and a one-cycle done pulse is returned to it on expiry. Dropping the
// request while running aborts without a done pulse.
//
// Ports:
//   clk        in  1             system clock
//   rst_n      in  1             asynchronous active-low reset
//   req        in  NREQ          per-requester request level
//   dly        in  NREQ*DW       per-requester delay, slice i = dly[i*DW +: DW]
//   grant      out NREQ          one-hot owner of the timer
//   done       out NREQ          one-cycle expiry pulse to the owner
//   busy       out 1             timer in RUN or DONE
//   remaining  out DW            ticks left for the current owner
//   owner      out $clog2(NREQ)  current or most recent winner
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; arbitrate pending requests, load delay on a win
// RUN     | owner holds grant; prescaler runs, remaining counts down
// DONE    | one-cycle done pulse to owner, grant already released
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = DEF_DW,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      dly,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [DW-1:0]           remaining,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   owner_nxt;
    logic [NREQ-1:0] grant_nxt, done_nxt;
    logic [DW-1:0]   rem_nxt;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [DW-1:0]   dly_slice [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign dly_slice[g] = dly[g*DW +: DW];
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req  (req),
        .last (last),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Derived from the state register only, so reset drops it immediately
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            presc     <= '0;
            last      <= IW'(NREQ - 1);
            owner     <= '0;
            grant     <= '0;
            done      <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            remaining <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        last_nxt  = last;
        owner_nxt = owner;
        grant_nxt = grant;
        done_nxt  = '0;
        rem_nxt   = remaining;

        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                rem_nxt   = '0;
                presc_nxt = '0;
                if (arb_any) begin
                    state_nxt = ST_RUN;
                    grant_nxt = arb_gnt;
                    owner_nxt = arb_idx;
                    last_nxt  = arb_idx;
                    rem_nxt   = dly_slice[arb_idx];
                end
            end

            ST_RUN: begin
                if (!req[owner]) begin
                    // Abort: owner withdrew, no done pulse, last keeps owner
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    rem_nxt   = '0;
                    presc_nxt = '0;
                end else if (remaining == '0) begin
                    // Zero delay expires on the first RUN cycle
                    state_nxt       = ST_DONE;
                    grant_nxt       = '0;
                    done_nxt[owner] = 1'b1;
                end else if (presc == PW'(PRESCALE - 1)) begin
                    presc_nxt = '0;
                    if (remaining == DW'(1)) begin
                        state_nxt       = ST_DONE;
                        grant_nxt       = '0;
                        rem_nxt         = '0;
                        done_nxt[owner] = 1'b1;
                    end else begin
                        rem_nxt = remaining - 1'b1;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                presc_nxt = '0;
            end

            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                rem_nxt   = '0;
                presc_nxt = '0;
            end
        endcase
    end

endmodule
